ucsbece154b_mem_arbiter: RTL and testbench

//  Shares one unified memory port between the fetch stage (PCF/InstrF) and the

---
 rtl/ucsbece154b_mem_arbiter.sv | 119 +++++++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_mem_arbiter.sv
// Arbiter that lets the fetch and memory stages share one memory port.
// The data side wins ties, and a watchdog sets a sticky error flag if memory stops responding.
module ucsbece154b_mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_kill_i,
   output logic        if_valid_o,
   output logic [31:0] if_rdata_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_valid_o,
   output logic [31:0] dm_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_fetch_o,
   output logic        stall_mem_o,
   output logic        err_o
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] IF_REQ  = 3'd1;
   localparam logic [2:0] IF_WAIT = 3'd2;
   localparam logic [2:0] DM_REQ  = 3'd3;
   localparam logic [2:0] DM_WAIT = 3'd4;
   localparam logic [2:0] RESP    = 3'd5;

   localparam logic [4:0] TMO_MAX  = 5'(TIMEOUT);
   localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

   logic [2:0]  state, state_next;
   logic        owner_dm;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic        kill_q;
   logic [4:0]  tmo_cnt;
   logic        in_req_wait;

   assign in_req_wait = (state == IF_REQ) || (state == IF_WAIT) ||
                        (state == DM_REQ) || (state == DM_WAIT);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         IDLE:    if (dm_req_i) state_next = DM_REQ;
                  else if (if_req_i) state_next = IF_REQ;
         IF_REQ:  if (if_kill_i) state_next = IDLE;
                  else if (mem_gnt_i) state_next = IF_WAIT;
         IF_WAIT: if (mem_rvalid_i) state_next = RESP;
         DM_REQ:  if (mem_gnt_i) state_next = DM_WAIT;
         DM_WAIT: if (mem_rvalid_i) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner_dm   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         kill_q     <= 1'b0;
         tmo_cnt    <= '0;
         err_o      <= 1'b0;
         if_rdata_o <= '0;
         dm_rdata_o <= '0;
      end else begin
         state <= state_next;

         // Request attributes are frozen when leaving IDLE; later requester changes are ignored.
         if (state == IDLE && state_next != IDLE) begin
            owner_dm <= dm_req_i;
            we_q     <= dm_req_i & dm_we_i;
            addr_q   <= dm_req_i ? dm_addr_i : if_addr_i;
            if (dm_req_i) wdata_q <= dm_wdata_i;
         end

         if (state == IF_WAIT && if_kill_i) kill_q <= 1'b1;
         else if (state == RESP)            kill_q <= 1'b0;

         if (state == IF_WAIT && mem_rvalid_i && !(kill_q || if_kill_i))
            if_rdata_o <= mem_rdata_i;
         if (state == DM_WAIT && mem_rvalid_i && !we_q)
            dm_rdata_o <= mem_rdata_i;

         // Watchdog counts consecutive cycles spent in one REQ/WAIT state.
         if (state_next != state)                   tmo_cnt <= '0;
         else if (in_req_wait && tmo_cnt < TMO_MAX) tmo_cnt <= tmo_cnt + 5'd1;

         if (in_req_wait && state_next == state && tmo_cnt == TMO_LAST)
            err_o <= 1'b1;
      end
   end

   assign mem_req_o   = (state == IF_REQ) || (state == DM_REQ);
   assign mem_we_o    = we_q && (state == DM_REQ);
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   assign if_valid_o = (state == RESP) && !owner_dm && !kill_q && !if_kill_i;
   assign dm_valid_o = (state == RESP) && owner_dm;

   assign stall_fetch_o = if_req_i & ~if_valid_o;
   assign stall_mem_o   = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Bench for the fetch/data memory arbiter: directed scenarios, then randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_ucsbece154b_mem_arbiter;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_kill, dm_req, dm_we, gnt, rvalid;
   logic [31:0] if_addr, dm_addr, dm_wdata, rdata;
   logic        if_valid, dm_valid, mem_req, mem_we, stall_fetch, stall_mem, err;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

   int checks = 0;
   int errors = 0;

   ucsbece154b_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_kill_i(if_kill),
      .if_valid_o(if_valid), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_valid_o(dm_valid), .dm_rdata_o(dm_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
      .stall_fetch_o(stall_fetch), .stall_mem_o(stall_mem), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      check(name, {31'b0, act}, {31'b0, exp});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Transaction model: one outstanding access with its progress flags.
   bit          m_active, m_dm, m_we, m_granted, m_responded, m_killed;
   logic [31:0] m_addr, m_wdata;
   int          m_dwell;
   logic [31:0] ex_if_rdata, ex_dm_rdata;
   bit          ex_err;

   task automatic dwell_tick();
      m_dwell++;
      if (m_dwell >= TIMEOUT) ex_err = 1'b1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_killed = 0; m_granted = 0; m_responded = 0; m_dwell = 0;
         ex_if_rdata = '0; ex_dm_rdata = '0; ex_err = 0;
      end else if (!m_active) begin
         if (dm_req || if_req) begin
            m_active = 1; m_granted = 0; m_responded = 0; m_killed = 0; m_dwell = 0;
            m_dm = dm_req;
            m_we = dm_req && dm_we;
            m_addr = dm_req ? dm_addr : if_addr;
            m_wdata = dm_wdata;
         end
      end else if (!m_granted) begin
         if (!m_dm && if_kill) m_active = 0;
         else if (gnt) begin m_granted = 1; m_dwell = 0; end
         else dwell_tick();
      end else if (!m_responded) begin
         if (!m_dm && if_kill) m_killed = 1;
         if (rvalid) begin
            m_responded = 1; m_dwell = 0;
            if (!m_dm && !m_killed) ex_if_rdata = rdata;
            if (m_dm && !m_we) ex_dm_rdata = rdata;
         end else dwell_tick();
      end else begin
         m_active = 0;
      end
   end

   bit cmp_en = 0;
   bit seen_if_valid, seen_dm_valid;

   always @(negedge clk) begin
      bit e_req, e_ifv, e_dmv;
      e_req = m_active && !m_granted;
      e_ifv = m_active && m_responded && !m_dm && !m_killed && !if_kill;
      e_dmv = m_active && m_responded && m_dm;
      seen_if_valid = e_ifv;
      seen_dm_valid = e_dmv;
      if (cmp_en) begin
         check_b("cmp_mem_req", mem_req, e_req);
         if (e_req) begin
            check("cmp_mem_addr", mem_addr, m_addr);
            check_b("cmp_mem_we", mem_we, m_we);
            if (m_we) check("cmp_mem_wdata", mem_wdata, m_wdata);
         end
         check_b("cmp_if_valid", if_valid, e_ifv);
         check_b("cmp_dm_valid", dm_valid, e_dmv);
         check("cmp_if_rdata", if_rdata, ex_if_rdata);
         check("cmp_dm_rdata", dm_rdata, ex_dm_rdata);
         check_b("cmp_stall_fetch", stall_fetch, if_req && !e_ifv);
         check_b("cmp_stall_mem", stall_mem, dm_req && !e_dmv);
         check_b("cmp_err", err, ex_err);
      end
   end

   initial begin
      rst_n = 1'b0;
      if_req = 0; if_kill = 0; dm_req = 0; dm_we = 0; gnt = 0; rvalid = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0; rdata = '0;
      repeat (3) cyc();
      cmp_en = 1;
      @(negedge clk);
      check_b("rst_mem_req", mem_req, 1'b0);
      check_b("rst_err", err, 1'b0);
      check("rst_if_rdata", if_rdata, 32'h0);
      rst_n = 1'b1;
      repeat (2) cyc();

      // 1: single fetch, best-case latency
      cyc(); if_req = 1; if_addr = 32'h0000_0000;
      @(negedge clk); check_b("t1_stall_t0", stall_fetch, 1'b1);
      cyc(); gnt = 1;
      @(negedge clk); check_b("t1_mem_req", mem_req, 1'b1); check("t1_mem_addr", mem_addr, 32'h0);
      cyc(); gnt = 0; rvalid = 1; rdata = 32'h0050_0113;
      @(negedge clk); check_b("t1_stall_t2", stall_fetch, 1'b1);
      cyc(); rvalid = 0;
      @(negedge clk);
      check_b("t1_if_valid", if_valid, 1'b1);
      check("t1_if_rdata", if_rdata, 32'h0050_0113);
      check_b("t1_stall_t3", stall_fetch, 1'b0);
      cyc(); if_req = 0;

      // 2: simultaneous fetch and load; the load goes first
      cyc(); if_req = 1; if_addr = 32'h4; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
      cyc(); gnt = 1;
      @(negedge clk);
      check("t2_mem_addr_dm", mem_addr, 32'h100);
      check_b("t2_mem_we", mem_we, 1'b0);
      cyc(); gnt = 0; rvalid = 1; rdata = 32'h1234_5678;
      cyc(); rvalid = 0;
      @(negedge clk);
      check_b("t2_dm_valid", dm_valid, 1'b1);
      check("t2_dm_rdata", dm_rdata, 32'h1234_5678);
      check_b("t2_stall_fetch_held", stall_fetch, 1'b1);
      cyc(); dm_req = 0;
      cyc(); gnt = 1;
      @(negedge clk); check("t2_mem_addr_if", mem_addr, 32'h4);
      cyc(); gnt = 0; rvalid = 1; rdata = 32'h0000_0013;
      cyc(); rvalid = 0;
      @(negedge clk); check_b("t2_if_valid", if_valid, 1'b1);
      cyc(); if_req = 0;

      // 3: store leaves load data untouched
      cyc(); dm_req = 1; dm_we = 1; dm_addr = 32'h104; dm_wdata = 32'hDEAD_BEEF;
      cyc(); gnt = 1;
      @(negedge clk);
      check_b("t3_mem_we", mem_we, 1'b1);
      check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("t3_mem_addr", mem_addr, 32'h104);
      cyc(); gnt = 0; rvalid = 1; rdata = 32'hFFFF_FFFF;
      cyc(); rvalid = 0;
      @(negedge clk);
      check_b("t3_dm_valid", dm_valid, 1'b1);
      check("t3_dm_rdata_kept", dm_rdata, 32'h1234_5678);
      cyc(); dm_req = 0; dm_we = 0;

      // 4: kill while waiting for the fetch response
      cyc(); if_req = 1; if_addr = 32'h8;
      cyc(); gnt = 1;
      cyc(); gnt = 0; if_kill = 1;
      cyc(); if_kill = 0; if_addr = 32'h200;
      cyc();
      cyc(); rvalid = 1; rdata = 32'hBAD0_0BAD;
      cyc(); rvalid = 0;
      @(negedge clk);
      check_b("t4_no_valid", if_valid, 1'b0);
      check("t4_rdata_kept", if_rdata, 32'h0000_0013);
      cyc();
      cyc(); gnt = 1;
      @(negedge clk); check("t4_refetch_addr", mem_addr, 32'h200);
      cyc(); gnt = 0; rvalid = 1; rdata = 32'h0000_0297;
      cyc(); rvalid = 0;
      @(negedge clk);
      check_b("t4_if_valid", if_valid, 1'b1);
      check("t4_if_rdata", if_rdata, 32'h0000_0297);
      cyc(); if_req = 0;

      // 5: grant withheld past the timeout
      cyc(); if_req = 1; if_addr = 32'h300;
      for (int k = 1; k <= 20; k++) begin
         cyc(); gnt = 0;
         @(negedge clk);
         if (k == 16) check_b("t5_err_before", err, 1'b0);
         if (k == 17) check_b("t5_err_set", err, 1'b1);
      end
      cyc(); gnt = 1;
      cyc(); gnt = 0; rvalid = 1; rdata = 32'h0000_0073;
      cyc(); rvalid = 0;
      @(negedge clk);
      check_b("t5_if_valid", if_valid, 1'b1);
      check_b("t5_err_sticky", err, 1'b1);
      cyc(); if_req = 0;

      // 6: reset in the middle of a load
      cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h108;
      cyc(); gnt = 1;
      cyc(); gnt = 0;
      #2 rst_n = 1'b0;
      #1;
      check_b("t6_mem_req", mem_req, 1'b0);
      check_b("t6_err", err, 1'b0);
      check("t6_dm_rdata", dm_rdata, 32'h0);
      check("t6_if_rdata", if_rdata, 32'h0);
      check("t6_mem_addr", mem_addr, 32'h0);
      check_b("t6_dm_valid", dm_valid, 1'b0);
      cyc(); dm_addr = 32'h10C;
      #2 rst_n = 1'b1;
      cyc(); gnt = 1;
      @(negedge clk); check("t6_new_addr", mem_addr, 32'h10C);
      cyc(); gnt = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
      cyc(); rvalid = 0;
      @(negedge clk);
      check_b("t6_dm_valid_after", dm_valid, 1'b1);
      check("t6_dm_rdata_after", dm_rdata, 32'hCAFE_F00D);
      cyc(); dm_req = 0;

      // Randomized traffic with a randomly responding memory
      for (int n = 0; n < 3000; n++) begin
         cyc();
         gnt    = ($urandom_range(0, 3) != 0);
         rvalid = ($urandom_range(0, 2) != 0);
         rdata  = $urandom;
         if_kill = 0;
         if (if_req) begin
            if (seen_if_valid) begin
               if_req  = ($urandom_range(0, 3) != 0);
               if_addr = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 9) == 0) begin
               if_kill = 1;
               if_addr = $urandom & 32'hFFFF_FFFC;
            end
         end else if ($urandom_range(0, 2) == 0) begin
            if_req  = 1;
            if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (dm_req) begin
            if (seen_dm_valid) begin
               dm_req   = ($urandom_range(0, 2) == 0);
               dm_we    = $urandom_range(0, 1) != 0;
               dm_addr  = $urandom & 32'hFFFF_FFFC;
               dm_wdata = $urandom;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            dm_req   = 1;
            dm_we    = $urandom_range(0, 1) != 0;
            dm_addr  = $urandom & 32'hFFFF_FFFC;
            dm_wdata = $urandom;
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
